dm_bus_bridge: RTL and testbench
================================

Name: dm_bus_bridge

Overview:
- Sits directly downstream of the RV32I core's MEM stage, between its SRAM-style data-memory port (DM_OE/DM_WEB/DM_A/DM_DI/DM_DO) and a variable-latency valid/ready memory bus.
- Posts stores into a small write buffer so the core does not stall on them.
- Serialises loads behind buffered stores and raises dm_stall while a load is pending.

Parameters:
WBUF_DEPTH, 2, write-buffer entries; power of two, >=2
TIMEOUT, 64, max cycles in RD_WAIT before the load is aborted

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
DM_OE  in  1  load request (valid only when DM_WEB==4'hF)
DM_WEB  in  4  active-low byte write enables; !=4'hF means store
DM_A  in  14  word address
DM_DI  in  32  store data, already lane-aligned
DM_DO  out  32  load data, registered
dm_stall  out  1  core must hold its DM_* inputs stable while high
bus_req_valid  out  1  request valid
bus_req_ready  in  1  request accepted when valid&&ready at clock edge
bus_req_we  out  1  1=write, 0=read
bus_req_be  out  4  active-high byte enables
bus_req_addr  out  16  byte address = {addr,2'b00}
bus_req_wdata  out  32  write data
bus_rsp_valid  in  1  read data valid (reads only)
bus_rsp_rdata  in  32  read data
bus_err  out  1  sticky error flag

Behaviour:
- Reset (async, rst=1): FSM=IDLE, write buffer empty, timeout counter=0. Outputs: DM_DO=0, dm_stall=0, bus_req_valid=0, bus_req_we=0, bus_req_be=0, bus_req_addr=0, bus_req_wdata=0, bus_err=0.
- Reset mid-transaction: buffered stores and any outstanding load are discarded.
- Request decode each cycle:
  - store = (DM_WEB!=4'hF).
  - load = DM_OE && DM_WEB==4'hF.
  - If DM_OE and a store are asserted together, the cycle is treated as a store only.
- Stores:
  - In IDLE, a store with buffer count<WBUF_DEPTH is enqueued {DM_A, ~DM_WEB, DM_DI} at the edge, with dm_stall=0 (zero-latency posted write).
  - If count==WBUF_DEPTH, dm_stall=1 until count<WBUF_DEPTH.
  - dm_stall is computed from registered count only. A same-cycle dequeue does not free the slot, so there is no combinational path from bus_req_ready.
- Buffer drain:
  - When the buffer is non-empty and the FSM is not in RD_REQ/RD_WAIT, the bus drives the head entry: bus_req_valid=1, we=1, be/addr/wdata from the head.
  - Payload is held stable until bus_req_ready. The entry is popped on valid&&ready.
  - Entries drain in FIFO order. Pointers wrap modulo WBUF_DEPTH.
  - Enqueue and dequeue in the same cycle leave count unchanged.
- Load FSM states: IDLE, RD_DRAIN, RD_REQ, RD_WAIT, RD_DONE.
  - IDLE: a load sets dm_stall=1 combinationally. Next state is RD_DRAIN if the buffer is non-empty, else RD_REQ.
  - RD_DRAIN: dm_stall=1; move to RD_REQ once count==0. Loads never bypass older stores; there is no forwarding.
  - RD_REQ: bus_req_valid=1, we=0, be=4'hF, addr={DM_A,2'b00}, dm_stall=1. On ready, go to RD_WAIT and clear the timeout counter.
  - RD_WAIT: dm_stall=1, counter increments each cycle.
    - On bus_rsp_valid: DM_DO<=bus_rsp_rdata, go to RD_DONE.
    - If the counter reaches TIMEOUT-1 without a response: DM_DO<=0, bus_err<=1, go to RD_DONE.
    - A response and the timeout in the same cycle: the response wins and there is no error.
  - RD_DONE: dm_stall=0 for exactly one cycle. The core consumes the load at this edge. Next state is IDLE, and this held load is not re-issued.
- Minimum load latency: a load with an empty buffer and ready=1 and a 1-cycle response spends 3 stalled cycles before RD_DONE.
- DM_DO holds its value until the next load completes.
- bus_rsp_valid outside RD_WAIT is ignored and sets bus_err.
- bus_err clears only on reset.
- A store enqueued in the RD_DONE cycle is illegal; the core cannot present one there, so no handling is required.

Test Plan:
- Reset then idle: all outputs 0, dm_stall=0; after release with no requests, bus_req_valid stays 0.
- Two back-to-back stores (A=0x0010 WEB=0000 DI=0x11111111; A=0x0011 WEB=1110 DI=0x000000AB), bus_req_ready=0 -> dm_stall stays 0 for both. A third store stalls. Raising ready gives bus writes addr 0x0040 be=F, then 0x0044 be=1 in order, and the third store is then enqueued.
- Load A=0x0020 with empty buffer, ready=1, response 0xCAFEF00D two cycles after acceptance -> bus read addr=0x0080 be=F. DM_DO=0xCAFEF00D in the RD_DONE cycle, dm_stall falls exactly then, and exactly one read is issued.
- Store A=0x0005 then load A=0x0005 next cycle with ready stalled 3 cycles -> the write issues before the read, and the FSM passes through RD_DRAIN.
- Load with no response for TIMEOUT cycles -> DM_DO=0, bus_err=1, dm_stall drops; a stray bus_rsp_valid in IDLE also sets bus_err.
- Assert rst during RD_WAIT with 2 buffered stores -> outputs return to reset values immediately; no further bus requests after release.

Source files
------------

// File: rtl/dm_bus_bridge_if.sv
// Memory-bus side of the data-memory bridge: a valid/ready request channel
// plus a read-response channel (responses carry read data only).
interface dm_bus_bridge_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_we;
    logic [3:0]  bus_req_be;
    logic [15:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;

    // Bridge side: issues requests, consumes responses.
    modport master (
        output bus_req_valid,
        output bus_req_we,
        output bus_req_be,
        output bus_req_addr,
        output bus_req_wdata,
        input  bus_req_ready,
        input  bus_rsp_valid,
        input  bus_rsp_rdata
    );

    // Memory side: accepts requests, returns read data.
    modport slave (
        input  bus_req_valid,
        input  bus_req_we,
        input  bus_req_be,
        input  bus_req_addr,
        input  bus_req_wdata,
        output bus_req_ready,
        output bus_rsp_valid,
        output bus_rsp_rdata
    );
endinterface

// File: rtl/dm_bus_bridge.sv
// Bridge from the core's SRAM-style data-memory port to a valid/ready bus.
// Stores are posted into a small FIFO write buffer; loads wait for the
// buffer to drain, then issue a single read and stall the core until the
// response (or a timeout) arrives.
module dm_bus_bridge #(
    parameter int WBUF_DEPTH = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   DM_OE,
    input  logic [3:0]             DM_WEB,
    input  logic [13:0]            DM_A,
    input  logic [31:0]            DM_DI,
    output logic [31:0]            DM_DO,
    output logic                   dm_stall,
    output logic                   bus_err,
    dm_bus_bridge_if.master        bus
);

    localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(WBUF_DEPTH + 1);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WBUF_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_DRAIN,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_DONE
    } state_t;

    // Load FSM and its registered results
    state_t             state_q,   state_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [31:0]        dm_do_q,   dm_do_d;
    logic               bus_err_q, bus_err_d;

    // Write-buffer bookkeeping
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    // Write-buffer payload storage (no reset needed: count gates validity)
    logic [13:0]        wbuf_addr [WBUF_DEPTH];
    logic [3:0]         wbuf_be   [WBUF_DEPTH];
    logic [31:0]        wbuf_data [WBUF_DEPTH];

    // Request decode; a store always wins over a simultaneous DM_OE
    logic is_store;
    logic is_load;
    logic buf_empty;
    logic buf_full;
    logic enq;
    logic drain_active;
    logic deq;

    assign is_store  = (DM_WEB != 4'hF);
    assign is_load   = DM_OE && !is_store;
    assign buf_empty = (count_q == '0);
    assign buf_full  = (count_q == FULL_CNT);

    // Stores are only posted from IDLE; the read phases own the bus so the
    // buffer drains everywhere else.
    assign enq          = (state_q == ST_IDLE) && is_store && !buf_full;
    assign drain_active = !buf_empty && (state_q != ST_RD_REQ) && (state_q != ST_RD_WAIT);
    assign deq          = drain_active && bus.bus_req_ready;

    assign DM_DO   = dm_do_q;
    assign bus_err = bus_err_q;

    // Write-buffer pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Write-buffer payload capture at the tail
    always_ff @(posedge clk) begin
        if (enq) begin
            wbuf_addr[wr_ptr_q] <= DM_A;
            wbuf_be[wr_ptr_q]   <= ~DM_WEB;
            wbuf_data[wr_ptr_q] <= DM_DI;
        end
    end

    // Write-buffer pointer/count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Bus request mux: the pending read has priority, otherwise drain the head
    always_comb begin
        bus.bus_req_valid = 1'b0;
        bus.bus_req_we    = 1'b0;
        bus.bus_req_be    = 4'h0;
        bus.bus_req_addr  = 16'h0000;
        bus.bus_req_wdata = 32'h0000_0000;
        if (state_q == ST_RD_REQ) begin
            bus.bus_req_valid = 1'b1;
            bus.bus_req_be    = 4'hF;
            bus.bus_req_addr  = {DM_A, 2'b00};
        end else if (drain_active) begin
            bus.bus_req_valid = 1'b1;
            bus.bus_req_we    = 1'b1;
            bus.bus_req_be    = wbuf_be[rd_ptr_q];
            bus.bus_req_addr  = {wbuf_addr[rd_ptr_q], 2'b00};
            bus.bus_req_wdata = wbuf_data[rd_ptr_q];
        end
    end

    // Core stall: uses only registered occupancy so bus_req_ready never
    // reaches dm_stall combinationally
    always_comb begin
        dm_stall = 1'b0;
        unique case (state_q)
            ST_IDLE:    dm_stall = is_load || (is_store && buf_full);
            ST_RD_DONE: dm_stall = 1'b0;
            default:    dm_stall = 1'b1;
        endcase
    end

    // Load FSM next-state, timeout counter, load data and sticky error
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        dm_do_d   = dm_do_q;
        bus_err_d = bus_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (is_load) begin
                    state_d = buf_empty ? ST_RD_REQ : ST_RD_DRAIN;
                end
            end
            ST_RD_DRAIN: begin
                // Loads never overtake older stores; no forwarding
                if (buf_empty) begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (bus.bus_req_ready) begin
                    state_d   = ST_RD_WAIT;
                    tmo_cnt_d = '0;
                end
            end
            ST_RD_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (bus.bus_rsp_valid) begin
                    // A response on the last allowed cycle still counts
                    dm_do_d = bus.bus_rsp_rdata;
                    state_d = ST_RD_DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    dm_do_d   = 32'h0000_0000;
                    bus_err_d = 1'b1;
                    state_d   = ST_RD_DONE;
                end
            end
            ST_RD_DONE: begin
                // Core consumes the load at this edge; do not re-issue it
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A response nobody asked for is a bus protocol error
        if (bus.bus_rsp_valid && (state_q != ST_RD_WAIT)) begin
            bus_err_d = 1'b1;
        end
    end

    // Load FSM registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tmo_cnt_q <= '0;
            dm_do_q   <= 32'h0000_0000;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            dm_do_q   <= dm_do_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_dm_bus_bridge.sv
// Bench for dm_bus_bridge: a core-side driver issues loads/stores in program
// order, a bus responder models memory with variable ready/latency, and a
// monitor compares every accepted bus request and every completed load
// against expectations queued by the driver from a flat word-memory model.
module tb_dm_bus_bridge;

    localparam int TIMEOUT = 64;
    localparam int DEPTH   = 2;

    typedef struct {
        bit          we;
        logic [3:0]  be;
        logic [15:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        DM_OE;
    logic [3:0]  DM_WEB;
    logic [13:0] DM_A;
    logic [31:0] DM_DI;
    logic [31:0] DM_DO;
    logic        dm_stall;
    logic        bus_err;

    dm_bus_bridge_if bus_if ();

    dm_bus_bridge #(
        .WBUF_DEPTH (DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .DM_OE    (DM_OE),
        .DM_WEB   (DM_WEB),
        .DM_A     (DM_A),
        .DM_DI    (DM_DI),
        .DM_DO    (DM_DO),
        .dm_stall (dm_stall),
        .bus_err  (bus_err),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    txn_t        exp_q [$];
    logic [31:0] ld_q  [$];
    logic [31:0] ref_mem [64];

    // responder controls (written only by the main process)
    int ready_mode  = 0;  // 0: never ready, 1: always ready, 2: random
    int lat_fixed   = 0;  // 0: random 1..4, else fixed response latency
    bit mute        = 1'b0;
    int stray_req   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // Present one core operation and queue the bus/load outcome it must cause
    task automatic present(input bit st, input logic [13:0] a, input logic [3:0] web,
                           input logic [31:0] di, input bit exp_zero);
        txn_t t;
        DM_A  = a;
        DM_DI = di;
        t.addr = {a, 2'b00};
        if (st) begin
            DM_WEB  = web;
            DM_OE   = 1'($urandom_range(0, 1));
            t.we    = 1'b1;
            t.be    = ~web;
            t.wdata = di;
            ref_mem[a[5:0]] = merge(ref_mem[a[5:0]], di, ~web);
        end else begin
            DM_WEB  = 4'hF;
            DM_OE   = 1'b1;
            t.we    = 1'b0;
            t.be    = 4'hF;
            t.wdata = 32'h0;
            ld_q.push_back(exp_zero ? 32'h0 : ref_mem[a[5:0]]);
        end
        exp_q.push_back(t);
    endtask

    // Present an op, hold it until dm_stall is low, return stalled cycle count
    task automatic do_op(input bit st, input logic [13:0] a, input logic [3:0] web,
                         input logic [31:0] di, input bit exp_zero, output int cyc);
        cyc = 0;
        present(st, a, web, di, exp_zero);
        forever begin
            @(negedge clk);
            if (!dm_stall) break;
            cyc++;
            if (cyc > 200) begin
                chk("op_stall_bound", 32'(cyc), 32'd200);
                break;
            end
        end
        @(posedge clk);
        #1;
        DM_OE  = 1'b0;
        DM_WEB = 4'hF;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dm_do"},    DM_DO, 32'h0);
        chk({tag, "_dm_stall"}, 32'(dm_stall), 32'h0);
        chk({tag, "_bus_err"},  32'(bus_err), 32'h0);
        chk({tag, "_valid"},    32'(bus_if.bus_req_valid), 32'h0);
        chk({tag, "_we"},       32'(bus_if.bus_req_we), 32'h0);
        chk({tag, "_be"},       32'(bus_if.bus_req_be), 32'h0);
        chk({tag, "_addr"},     32'(bus_if.bus_req_addr), 32'h0);
        chk({tag, "_wdata"},    bus_if.bus_req_wdata, 32'h0);
    endtask

    // Bus responder: word memory with configurable ready and read latency
    initial begin : responder
        logic [31:0] bus_mem [64];
        bit          acc;
        bit          acc_we;
        logic [3:0]  acc_be;
        logic [15:0] acc_addr;
        logic [31:0] acc_wdata;
        int          rd_cnt;
        logic [5:0]  rd_idx;
        int          stray_served;
        for (int i = 0; i < 64; i++) bus_mem[i] = 32'h0;
        rd_cnt       = 0;
        rd_idx       = 6'h0;
        stray_served = 0;
        bus_if.bus_req_ready = 1'b0;
        bus_if.bus_rsp_valid = 1'b0;
        bus_if.bus_rsp_rdata = 32'h0;
        forever begin
            @(negedge clk);
            acc       = bus_if.bus_req_valid && bus_if.bus_req_ready && !rst;
            acc_we    = bus_if.bus_req_we;
            acc_be    = bus_if.bus_req_be;
            acc_addr  = bus_if.bus_req_addr;
            acc_wdata = bus_if.bus_req_wdata;
            @(posedge clk);
            #2;
            bus_if.bus_rsp_valid = 1'b0;
            bus_if.bus_rsp_rdata = $urandom;
            if (rst) begin
                rd_cnt = 0;
            end else begin
                if (acc && acc_we)
                    bus_mem[acc_addr[7:2]] = merge(bus_mem[acc_addr[7:2]], acc_wdata, acc_be);
                if (acc && !acc_we) begin
                    rd_cnt = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
                    rd_idx = acc_addr[7:2];
                end
                if (mute) rd_cnt = 0;
                if (rd_cnt != 0) begin
                    if (rd_cnt == 1) begin
                        bus_if.bus_rsp_valid = 1'b1;
                        bus_if.bus_rsp_rdata = bus_mem[rd_idx];
                    end
                    rd_cnt--;
                end
                if (stray_req != stray_served) begin
                    bus_if.bus_rsp_valid = 1'b1;
                    stray_served++;
                end
            end
            case (ready_mode)
                0:       bus_if.bus_req_ready = 1'b0;
                1:       bus_if.bus_req_ready = 1'b1;
                default: bus_if.bus_req_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compare accepted bus requests and completed loads in order
    initial begin : monitor
        txn_t        t;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus_if.bus_req_valid && bus_if.bus_req_ready) begin
                    $display("bus req we=%0d addr=%04h be=%h wdata=%08h", bus_if.bus_req_we,
                             bus_if.bus_req_addr, bus_if.bus_req_be, bus_if.bus_req_wdata);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_req_addr", 32'(bus_if.bus_req_addr), 32'hFFFF_FFFF);
                    end else begin
                        t = exp_q.pop_front();
                        chk("req_we",   32'(bus_if.bus_req_we), 32'(t.we));
                        chk("req_addr", 32'(bus_if.bus_req_addr), 32'(t.addr));
                        chk("req_be",   32'(bus_if.bus_req_be), 32'(t.be));
                        if (t.we) chk("req_wdata", bus_if.bus_req_wdata, t.wdata);
                    end
                end
                if (DM_OE && DM_WEB == 4'hF && !dm_stall) begin
                    $display("load done addr=%04h data=%08h", {DM_A, 2'b00}, DM_DO);
                    if (ld_q.size() == 0) begin
                        chk("unexpected_load", DM_DO, 32'hFFFF_FFFF);
                    end else begin
                        e = ld_q.pop_front();
                        chk("load_data", DM_DO, e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : main
        int cyc;
        int cyc2;
        bit st;
        logic [3:0] web;
        DM_OE  = 1'b0;
        DM_WEB = 4'hF;
        DM_A   = 14'h0;
        DM_DI  = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

        // Reset state and quiet idle
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_req", 32'(bus_if.bus_req_valid), 32'h0);
        end
        idle(1);

        // Two posted stores with bus blocked, third stalls until a slot frees
        do_op(1, 14'h0010, 4'b0000, 32'h1111_1111, 0, cyc);
        chk("st1_stall_cycles", 32'(cyc), 32'd0);
        do_op(1, 14'h0011, 4'b1110, 32'h0000_00AB, 0, cyc);
        chk("st2_stall_cycles", 32'(cyc), 32'd0);
        fork
            do_op(1, 14'h0012, 4'b0011, 32'h1234_5678, 0, cyc);
            begin repeat (3) @(posedge clk); #1 ready_mode = 1; end
        join
        chk("st3_stall_cycles", 32'(cyc), 32'd4);
        idle(6);

        // Single load, empty buffer, response two cycles after acceptance
        lat_fixed = 2;
        do_op(1, 14'h0020, 4'b0000, 32'hCAFE_F00D, 0, cyc);
        idle(5);
        do_op(0, 14'h0020, 4'hF, 32'h0, 0, cyc);
        chk("ld_stall_cycles", 32'(cyc), 32'd4);
        idle(3);
        chk("ld_single_read", 32'(exp_q.size()), 32'd0);

        // Store then dependent load while the bus is blocked: drain first
        ready_mode = 0;
        lat_fixed  = 1;
        fork
            begin
                do_op(1, 14'h0005, 4'b0000, 32'hDEAD_BEEF, 0, cyc2);
                do_op(0, 14'h0005, 4'hF, 32'h0, 0, cyc);
            end
            begin repeat (4) @(posedge clk); #1 ready_mode = 1; end
        join
        chk("st_before_ld_stall", 32'(cyc2), 32'd0);
        chk("ld_after_st_stall", 32'(cyc), 32'd7);
        idle(4);
        do_op(1, 14'h0006, 4'b0000, 32'h0BAD_0BAD, 0, cyc);
        idle(4);
        chk("dm_do_held", DM_DO, 32'hDEAD_BEEF);

        // Randomized mixed traffic
        ready_mode = 2;
        lat_fixed  = 0;
        for (int n = 0; n < 150; n++) begin
            st  = ($urandom_range(0, 2) != 0);
            web = 4'($urandom_range(0, 14));
            do_op(st, 14'($urandom_range(0, 63)), web, $urandom, 0, cyc);
            idle($urandom_range(0, 2));
        end
        idle(20);
        chk("err_after_random", 32'(bus_err), 32'h0);

        // Response on the last allowed cycle wins over the timeout
        ready_mode = 1;
        lat_fixed  = TIMEOUT;
        do_op(0, 14'h0005, 4'hF, 32'h0, 0, cyc);
        chk("late_rsp_stall", 32'(cyc), 32'(TIMEOUT + 2));
        @(negedge clk);
        chk("late_rsp_no_err", 32'(bus_err), 32'h0);
        idle(1);

        // No response at all: abort with zero data and sticky error
        mute = 1'b1;
        do_op(0, 14'h0020, 4'hF, 32'h0, 1, cyc);
        chk("timeout_stall", 32'(cyc), 32'(TIMEOUT + 2));
        @(negedge clk);
        chk("timeout_err", 32'(bus_err), 32'h1);
        chk("timeout_dm_do", DM_DO, 32'h0);
        idle(3);
        chk("err_sticky", 32'(bus_err), 32'h1);
        mute = 1'b0;

        // Reset clears the error; a stray response in IDLE sets it again
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst2");
        @(posedge clk);
        #1 rst = 1'b0;
        lat_fixed = 1;
        idle(2);
        stray_req++;
        @(negedge clk);
        chk("stray_err_before", 32'(bus_err), 32'h0);
        @(negedge clk);
        chk("stray_err_after", 32'(bus_err), 32'h1);
        idle(1);

        // Reset mid-transaction: buffered stores / outstanding read discarded
        for (int sc = 0; sc < 2; sc++) begin
            if (sc == 0) begin
                ready_mode = 0;
                do_op(1, 14'h0030, 4'b0000, 32'hA5A5_A5A5, 0, cyc);
                do_op(1, 14'h0031, 4'b0000, 32'h5A5A_5A5A, 0, cyc);
                present(0, 14'h0030, 4'hF, 32'h0, 0);
                idle(3);
            end else begin
                ready_mode = 1;
                mute       = 1'b1;
                present(0, 14'h0032, 4'hF, 32'h0, 0);
                idle(5);
                chk("rd_wait_stalled", 32'(dm_stall), 32'h1);
            end
            rst    = 1'b1;
            DM_OE  = 1'b0;
            DM_WEB = 4'hF;
            #1;
            chk_reset_outputs(sc == 0 ? "rst_drain" : "rst_wait");
            exp_q.delete();
            ld_q.delete();
            mute = 1'b0;
            @(posedge clk);
            #1 rst = 1'b0;
            ready_mode = 1;
            repeat (10) begin
                @(negedge clk);
                chk("no_req_after_rst", 32'(bus_if.bus_req_valid), 32'h0);
            end
            idle(1);
        end

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("ld_q_empty", 32'(ld_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
